// File: rtl/range_counter_pkg.sv
// Shared types and range helpers for the range counter.
// Range limits are returned as plain ints; callers cast to their own width.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_UNSIGNED = 2'd0,
        CNT_SIGNMAG  = 2'd1,
        CNT_TWOS     = 2'd2
    } mode_t;

    // Largest representable value for the given width and number format.
    function automatic int range_max(input int size, input mode_t mode);
        int r;
        case (mode)
            CNT_UNSIGNED: r = (1 << size) - 1;
            default:      r = (1 << (size - 1)) - 1;
        endcase
        return r;
    endfunction

    // Smallest representable value for the given width and number format.
    // Sign-magnitude is symmetric: the negative-zero code is not a value.
    function automatic int range_min(input int size, input mode_t mode);
        int r;
        case (mode)
            CNT_UNSIGNED: r = 0;
            CNT_SIGNMAG:  r = -((1 << (size - 1)) - 1);
            default:      r = -(1 << (size - 1));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/range_counter_if.sv
// Request/load/status bundle between a controller and the range counter.
interface range_counter_if #(
    parameter int Size      = 5,
    parameter int StepWidth = 1
);
    logic                 Up;
    logic                 Down;
    logic                 Load;
    logic [Size-1:0]      LoadData;
    logic [StepWidth-1:0] Step;
    logic [Size-1:0]      Data;
    logic                 AtMax;
    logic                 AtMin;
    logic                 Limit;

    modport master (
        output Up, Down, Load, LoadData, Step,
        input  Data, AtMax, AtMin, Limit
    );

    modport slave (
        input  Up, Down, Load, LoadData, Step,
        output Data, AtMax, AtMin, Limit
    );
endinterface

// File: rtl/range_counter_format.sv
// Combinational conversion between the counter's storage format and a
// signed integer two bits wider than the data, wide enough that adding or
// subtracting any legal step never overflows.
module count_format
    import counter_pkg::*;
#(
    parameter int    Size = 5,
    parameter mode_t Mode = CNT_SIGNMAG
) (
    input  logic [Size-1:0]        i_fmt,
    output logic signed [Size+1:0] o_int,
    input  logic signed [Size+1:0] i_int,
    output logic [Size-1:0]        o_fmt
);

    logic signed [Size+1:0] w_mag;
    logic signed [Size+1:0] w_neg;

    assign w_mag = {3'b000, i_fmt[Size-2:0]};
    assign w_neg = -i_int;

    // Decode the stored format into a signed integer.
    always_comb begin
        o_int = '0;
        case (Mode)
            CNT_UNSIGNED: o_int = {2'b00, i_fmt};
            CNT_SIGNMAG:  o_int = i_fmt[Size-1] ? -w_mag : w_mag;
            default:      o_int = {{2{i_fmt[Size-1]}}, i_fmt};
        endcase
    end

    // Encode an in-range signed integer; zero always encodes with sign bit 0.
    always_comb begin
        o_fmt = '0;
        case (Mode)
            CNT_UNSIGNED: o_fmt = i_int[Size-1:0];
            CNT_SIGNMAG:  o_fmt = i_int[Size+1] ? {1'b1, w_neg[Size-2:0]}
                                                : {1'b0, i_int[Size-2:0]};
            default:      o_fmt = i_int[Size-1:0];
        endcase
    end

endmodule

// File: rtl/range_counter.sv
// Saturating/wrapping up/down counter with selectable number format,
// variable step, optional edge-triggered requests and limit status flags.
module range_counter
    import counter_pkg::*;
#(
    parameter int    Size      = 5,
    parameter mode_t Mode      = CNT_SIGNMAG,
    parameter int    Wrap      = 0,
    parameter int    StepWidth = 1,
    parameter int    EdgeMode  = 0
) (
    input  logic          Clock,
    input  logic          Reset,
    range_counter_if.slave bus
);

    localparam logic signed [Size+1:0] MAX_INT = (Size+2)'(range_max(Size, Mode));
    localparam logic signed [Size+1:0] MIN_INT = (Size+2)'(range_min(Size, Mode));
    localparam logic signed [Size+1:0] RANGE_N = MAX_INT - MIN_INT + 1;

    if (Size < 2 || Size > 16) begin : g_bad_size
        $error("range_counter: Size must be within 2..16");
    end
    if (StepWidth < 1 || StepWidth > Size - 1) begin : g_bad_step
        $error("range_counter: StepWidth must be within 1..Size-1");
    end

    logic [Size-1:0]        r_data;
    logic                   r_at_max;
    logic                   r_at_min;
    logic                   r_limit;
    logic                   r_up_d;
    logic                   r_down_d;
    logic                   r_armed;

    logic signed [Size+1:0] w_data_int;
    logic signed [Size+1:0] w_load_int;
    logic signed [Size+1:0] w_load_clamp;
    logic [Size-1:0]        w_load_fmt;
    logic signed [Size+1:0] w_step_int;
    logic signed [Size+1:0] w_sum;
    logic signed [Size+1:0] w_count_int;
    logic [Size-1:0]        w_count_fmt;
    logic                   w_count_lim;
    logic                   w_up_ev;
    logic                   w_down_ev;
    logic                   w_event;
    logic signed [Size+1:0] w_next_int;
    logic [Size-1:0]        w_next_fmt;
    logic                   w_next_lim;

    count_format #(.Size(Size), .Mode(Mode)) u_fmt_data (
        .i_fmt (r_data),
        .o_int (w_data_int),
        .i_int (w_count_int),
        .o_fmt (w_count_fmt)
    );

    count_format #(.Size(Size), .Mode(Mode)) u_fmt_load (
        .i_fmt (bus.LoadData),
        .o_int (w_load_int),
        .i_int (w_load_clamp),
        .o_fmt (w_load_fmt)
    );

    assign w_step_int = {{(Size+2-StepWidth){1'b0}}, bus.Step};

    // r_armed masks the first cycle after reset so a request already high
    // when reset releases is not mistaken for a rising edge.
    assign w_up_ev   = (EdgeMode != 0) ? (bus.Up   & ~r_up_d   & r_armed) : bus.Up;
    assign w_down_ev = (EdgeMode != 0) ? (bus.Down & ~r_down_d & r_armed) : bus.Down;
    assign w_event   = w_up_ev ^ w_down_ev;

    // Apply the step and fold the result back into range (clamp or wrap).
    always_comb begin
        w_sum       = w_up_ev ? (w_data_int + w_step_int) : (w_data_int - w_step_int);
        w_count_int = w_sum;
        w_count_lim = 1'b0;
        if (w_sum > MAX_INT) begin
            w_count_int = (Wrap != 0) ? (w_sum - RANGE_N) : MAX_INT;
            w_count_lim = 1'b1;
        end else if (w_sum < MIN_INT) begin
            w_count_int = (Wrap != 0) ? (w_sum + RANGE_N) : MIN_INT;
            w_count_lim = 1'b1;
        end
    end

    // Clamp load values into range; negative zero already decodes to 0.
    always_comb begin
        w_load_clamp = w_load_int;
        if (w_load_int > MAX_INT) begin
            w_load_clamp = MAX_INT;
        end else if (w_load_int < MIN_INT) begin
            w_load_clamp = MIN_INT;
        end
    end

    // Select next value: load wins over a count event, otherwise hold.
    always_comb begin
        w_next_int = w_data_int;
        w_next_fmt = r_data;
        w_next_lim = 1'b0;
        if (bus.Load) begin
            w_next_int = w_load_clamp;
            w_next_fmt = w_load_fmt;
        end else if (w_event) begin
            w_next_int = w_count_int;
            w_next_fmt = w_count_fmt;
            w_next_lim = w_count_lim;
        end
    end

    // Register data, flags derived from the new value, and request history.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_data   <= '0;
            r_at_max <= 1'b0;
            r_at_min <= (Mode == CNT_UNSIGNED);
            r_limit  <= 1'b0;
            r_up_d   <= 1'b0;
            r_down_d <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_data   <= w_next_fmt;
            r_at_max <= (w_next_int == MAX_INT);
            r_at_min <= (w_next_int == MIN_INT);
            r_limit  <= w_next_lim;
            r_up_d   <= bus.Up;
            r_down_d <= bus.Down;
            r_armed  <= 1'b1;
        end
    end

    assign bus.Data  = r_data;
    assign bus.AtMax = r_at_max;
    assign bus.AtMin = r_at_min;
    assign bus.Limit = r_limit;

endmodule

// File: tb/tb_range_counter.sv
// Directed bench: four counter configurations driven side by side from one
// clock/reset, each checked against hand-computed values.
module tb_range_counter;
    import counter_pkg::*;

    logic Clock;
    logic Reset;

    int n_total = 0;
    int n_bad   = 0;

    range_counter_if #(.Size(5), .StepWidth(1)) if_sm ();
    range_counter_if #(.Size(5), .StepWidth(2)) if_u  ();
    range_counter_if #(.Size(5), .StepWidth(2)) if_t  ();
    range_counter_if #(.Size(5), .StepWidth(1)) if_e  ();

    range_counter #(.Size(5), .Mode(CNT_SIGNMAG), .Wrap(0), .StepWidth(1), .EdgeMode(0))
        u_sm (.Clock(Clock), .Reset(Reset), .bus(if_sm.slave));
    range_counter #(.Size(5), .Mode(CNT_UNSIGNED), .Wrap(0), .StepWidth(2), .EdgeMode(0))
        u_u (.Clock(Clock), .Reset(Reset), .bus(if_u.slave));
    range_counter #(.Size(5), .Mode(CNT_TWOS), .Wrap(1), .StepWidth(2), .EdgeMode(0))
        u_t (.Clock(Clock), .Reset(Reset), .bus(if_t.slave));
    range_counter #(.Size(5), .Mode(CNT_UNSIGNED), .Wrap(0), .StepWidth(1), .EdgeMode(1))
        u_e (.Clock(Clock), .Reset(Reset), .bus(if_e.slave));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        if_sm.Up = 0; if_sm.Down = 0; if_sm.Load = 0; if_sm.LoadData = '0; if_sm.Step = 1;
        if_u.Up  = 0; if_u.Down  = 0; if_u.Load  = 0; if_u.LoadData  = '0; if_u.Step  = 1;
        if_t.Up  = 0; if_t.Down  = 0; if_t.Load  = 0; if_t.LoadData  = '0; if_t.Step  = 1;
        if_e.Up  = 1; if_e.Down  = 0; if_e.Load  = 0; if_e.LoadData  = '0; if_e.Step  = 1;
        cyc();
        cyc();

        chk("rst_sm_data",  int'(if_sm.Data),  0);
        chk("rst_sm_atmin", int'(if_sm.AtMin), 0);
        chk("rst_sm_atmax", int'(if_sm.AtMax), 0);
        chk("rst_sm_limit", int'(if_sm.Limit), 0);
        chk("rst_u_atmin",  int'(if_u.AtMin),  1);
        chk("rst_t_atmin",  int'(if_t.AtMin),  0);
        chk("rst_e_atmin",  int'(if_e.AtMin),  1);

        Reset = 1'b1;

        // sign-magnitude walk down through zero and back up
        if_sm.Down = 1;
        cyc(); chk("sm_dn1", int'(if_sm.Data), 17);
        cyc(); chk("sm_dn2", int'(if_sm.Data), 18);
        cyc(); chk("sm_dn3", int'(if_sm.Data), 19);
        if_sm.Down = 0; if_sm.Up = 1;
        cyc(); chk("sm_up1", int'(if_sm.Data), 18);
        cyc(); chk("sm_up2", int'(if_sm.Data), 17);
        cyc(); chk("sm_up3_zero", int'(if_sm.Data), 0);
        cyc(); chk("sm_up4", int'(if_sm.Data), 1);
        chk("sm_up4_limit", int'(if_sm.Limit), 0);

        // Up and Down together hold
        if_sm.Down = 1;
        cyc(); chk("sm_both_data", int'(if_sm.Data), 1);
        chk("sm_both_limit", int'(if_sm.Limit), 0);
        if_sm.Up = 0; if_sm.Down = 0;

        // saturate at minimum
        if_sm.Load = 1; if_sm.LoadData = 5'b11111;
        cyc(); chk("sm_ld_min", int'(if_sm.Data), 31);
        chk("sm_ld_atmin", int'(if_sm.AtMin), 1);
        chk("sm_ld_limit", int'(if_sm.Limit), 0);
        if_sm.Load = 0; if_sm.Down = 1;
        cyc(); chk("sm_sat_data", int'(if_sm.Data), 31);
        chk("sm_sat_limit", int'(if_sm.Limit), 1);
        if_sm.Down = 0;
        cyc(); chk("sm_idle_limit", int'(if_sm.Limit), 0);

        // load beats up; negative zero loads as zero
        if_sm.Load = 1; if_sm.LoadData = 5'd7; if_sm.Up = 1;
        cyc(); chk("sm_ldup_data", int'(if_sm.Data), 7);
        chk("sm_ldup_limit", int'(if_sm.Limit), 0);
        if_sm.Up = 0; if_sm.LoadData = 5'b10000;
        cyc(); chk("sm_ld_negzero", int'(if_sm.Data), 0);
        if_sm.Load = 0;

        // unsigned saturation at max with step 3
        if_u.Load = 1; if_u.LoadData = 5'd30;
        cyc(); chk("u_ld30", int'(if_u.Data), 30);
        if_u.Load = 0; if_u.Step = 2'd3; if_u.Up = 1;
        cyc(); chk("u_sat1_data", int'(if_u.Data), 31);
        chk("u_sat1_atmax", int'(if_u.AtMax), 1);
        chk("u_sat1_limit", int'(if_u.Limit), 1);
        cyc(); chk("u_sat2_data", int'(if_u.Data), 31);
        chk("u_sat2_limit", int'(if_u.Limit), 1);
        if_u.Up = 0;
        cyc(); chk("u_idle_limit", int'(if_u.Limit), 0);

        // two's complement wrap both directions
        if_t.Load = 1; if_t.LoadData = 5'd14;
        cyc(); chk("t_ld14", int'(if_t.Data), 14);
        if_t.Load = 0; if_t.Step = 2'd3; if_t.Up = 1;
        cyc(); chk("t_wrap_up_data", int'(if_t.Data), 17);
        chk("t_wrap_up_limit", int'(if_t.Limit), 1);
        if_t.Up = 0; if_t.Down = 1; if_t.Step = 2'd2;
        cyc(); chk("t_wrap_dn_data", int'(if_t.Data), 15);
        chk("t_wrap_dn_limit", int'(if_t.Limit), 1);
        chk("t_wrap_dn_atmax", int'(if_t.AtMax), 1);
        if_t.Down = 0;

        // edge mode: Up held since reset never counted
        chk("e_held_reset", int'(if_e.Data), 0);
        if_e.Up = 0;
        cyc();
        if_e.Up = 1;
        repeat (10) cyc();
        chk("e_once_data", int'(if_e.Data), 1);
        chk("e_once_limit", int'(if_e.Limit), 0);
        if_e.Up = 0;
        cyc();
        if_e.Up = 1; if_e.Down = 1;
        cyc(); chk("e_both_data", int'(if_e.Data), 1);
        chk("e_both_limit", int'(if_e.Limit), 0);
        cyc();
        if_e.Up = 0; if_e.Down = 0;
        cyc();
        if_e.Down = 1;
        cyc(); chk("e_down_data", int'(if_e.Data), 0);
        if_e.Down = 0;

        // reset mid-count, then level count resumes right after release
        if_u.Load = 1; if_u.LoadData = 5'd9;
        cyc(); chk("u_ld9", int'(if_u.Data), 9);
        if_u.Load = 0; if_u.Step = 2'd1; if_u.Up = 1; Reset = 1'b0;
        cyc(); chk("u_rst_data", int'(if_u.Data), 0);
        chk("u_rst_limit", int'(if_u.Limit), 0);
        chk("u_rst_atmax", int'(if_u.AtMax), 0);
        Reset = 1'b1;
        cyc(); chk("u_after_rst", int'(if_u.Data), 1);
        if_u.Up = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/range_counter.md
RANGE_COUNTER -- requirements
Module: range_counter

Interface
REQ-001 SHALL have parameter Size, default 5, meaning Data width in bits (range 2..16).
REQ-002 SHALL have parameter Mode, default CNT_SIGNMAG, meaning number format: CNT_UNSIGNED, CNT_SIGNMAG (MSB sign, Size-1 magnitude) or CNT_TWOS.
REQ-003 SHALL have parameter Wrap, default 0, meaning 0 = saturate at limits, 1 = wrap modulo range.
REQ-004 SHALL have parameter StepWidth, default 1, meaning Step width in bits, 1..Size-1.
REQ-005 SHALL have parameter EdgeMode, default 0, meaning 0 = count every cycle Up/Down is high, 1 = count once per rising edge.
REQ-006 Clock  input  1  clock; all state updates on posedge.
REQ-007 Reset  input  1  synchronous, active-low reset.
REQ-008 Up  input  1  count-up request.
REQ-009 Down  input  1  count-down request.
REQ-010 Load  input  1  load LoadData into Data.
REQ-011 LoadData  input  Size  value to load, in Mode format.
REQ-012 Step  input  StepWidth  unsigned increment per count event; Step = 0 means no change.
REQ-013 Data  output  Size  registered count, Mode format.
REQ-014 AtMax  output  1  registered; high when Data equals range maximum.
REQ-015 AtMin  output  1  registered; high when Data equals range minimum.
REQ-016 Limit  output  1  registered one-cycle pulse when a count event saturated or wrapped.

Function
REQ-017 Ranges SHALL be: CNT_UNSIGNED 0..2^Size-1; CNT_SIGNMAG -(2^(Size-1)-1)..+(2^(Size-1)-1); CNT_TWOS -2^(Size-1)..2^(Size-1)-1.
REQ-018 Priority SHALL be Reset > Load > count event; Load ignores Up/Down/Step in that cycle.
REQ-019 Count event SHALL occur when exactly one of Up/Down is active (level, or rising edge if EdgeMode=1); Up and Down together SHALL hold Data and not pulse Limit.
REQ-020 Edge detection SHALL use Up/Down registered one cycle; a request held across reset deassertion SHALL NOT produce an edge.
REQ-021 Count latency SHALL be one clock: Data, AtMax, AtMin, Limit update on the edge sampling the request.
REQ-022 Arithmetic SHALL convert Data to signed integer of Size+2 bits, add/subtract Step, then range-check; no intermediate overflow allowed.
REQ-023 Saturate (Wrap=0): result above max -> max, below min -> min; Limit pulses if clamped.
REQ-024 Wrap (Wrap=1): result above max -> result - N, below min -> result + N, N = max-min+1; Limit pulses if wrapped.
REQ-025 Count event at a limit in saturate mode SHALL keep Data and pulse Limit.
REQ-026 CNT_SIGNMAG SHALL never output negative zero (1 followed by zeros); zero crossings pass through 0 with sign bit 0.
REQ-027 LoadData outside range SHALL be clamped (CNT_SIGNMAG negative zero -> 0); Load never pulses Limit.
REQ-028 AtMax/AtMin SHALL reflect the new Data in the same cycle Data updates.

Reset
REQ-029 Reset low at posedge SHALL set Data=0, AtMax=0, AtMin=1 only for CNT_UNSIGNED else 0, Limit=0, edge registers=0.
REQ-030 Reset mid-count SHALL abort any pending event; first count is possible on the edge after Reset rises (level mode).

Structure
REQ-031 Package counter_pkg SHALL hold typedef enum mode_t {CNT_UNSIGNED, CNT_SIGNMAG, CNT_TWOS} and min/max range functions of (Size, Mode).
REQ-032 Format conversion SHALL be one combinational sub-module, count_format, performing Mode-format <-> signed-integer conversion, instantiated for Data and LoadData.
REQ-033 Parameter legality (StepWidth, Size) SHALL be checked at elaboration.

Verification
REQ-034 Size=5, CNT_SIGNMAG, Wrap=0, Step=1: from 0 assert Down 3 cycles -> Data 5'b10001, 5'b10010, 5'b10011; then Up 4 cycles -> -2, -1, 0 (5'b00000), +1.
REQ-035 Size=5, CNT_UNSIGNED, Wrap=0: Load 30, Step=3, Up one cycle -> Data=31, AtMax=1, Limit=1; Up again -> Data=31, Limit=1.
REQ-036 Size=5, CNT_TWOS, Wrap=1: Load 14, Step=3, Up -> Data=-15 (5'b10001), Limit=1; Down Step=2 -> Data=15, Limit=1.
REQ-037 EdgeMode=1: Up held 10 cycles -> Data increments once; Up and Down rise together -> Data unchanged, Limit=0.
REQ-038 Load and Up same cycle with LoadData=7 -> Data=7; CNT_SIGNMAG LoadData=5'b10000 -> Data=0.
REQ-039 Data=9, Reset low while Up high -> next edge Data=0, Limit=0, AtMax=0.
